// File: rtl/adder_station_pkg.sv
// ---------------------------------------------------------------------------
// adder_station_pkg
// Shared constants for the adder reservation station: datapath widths,
// opcode values, instruction field positions, the READY tag encoding and
// the FSM state encodings. Optional feature macro used by the importing
// files: ADDER_FORWARD_EN.
// ---------------------------------------------------------------------------
package adder_station_pkg;

    localparam int WORD_SIZE = 32;
    localparam int RB_SIZE   = 8;
    localparam int RB_INDEX  = 3;
    localparam int REG_INDEX = 5;
    localparam int FU_INDEX  = 4;

    // Opcodes carried in inst[31:28]
    localparam logic [3:0] INST_ADD  = 4'd1;
    localparam logic [3:0] INST_SUB  = 4'd2;
    localparam logic [3:0] INST_ADDI = 4'd3;
    localparam logic [3:0] INST_SUBI = 4'd4;

    // Instruction field positions
    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 28;
    localparam int RD_MSB  = 27;
    localparam int RD_LSB  = 23;
    localparam int RS1_MSB = 22;
    localparam int RS1_LSB = 18;
    localparam int RS2_MSB = 17;
    localparam int RS2_LSB = 13;
    localparam int IMM_MSB = 12;
    localparam int IMM_W   = IMM_MSB + 1;

    // Status-table tag: MSB set means the operand value is already valid
    localparam logic [RB_INDEX:0] READY_TAG = {1'b1, {RB_INDEX{1'b0}}};

    // FSM state encodings
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_WAIT_OPS = 2'd1;
    localparam logic [1:0] ST_EXEC     = 2'd2;
    localparam logic [1:0] ST_BCAST    = 2'd3;

    function automatic logic [WORD_SIZE-1:0] sext_imm(input logic [IMM_W-1:0] imm);
        return {{(WORD_SIZE-IMM_W){imm[IMM_MSB]}}, imm};
    endfunction

endpackage

// File: rtl/adder_operand_slot.sv
// ---------------------------------------------------------------------------
// adder_operand_slot
// Holds one source operand (value, producer slot, ready flag) for the adder
// station. Loads from the register file / status table at capture, then
// snoops the data CDB for the producing lane while waiting.
// With ADDER_FORWARD_EN defined, a non-ready tag whose lane is valid in the
// capture cycle is taken directly from the CDB and reported ready at capture.
//
// Ports:
//   clk, reset_n    clock, asynchronous active-low reset
//   flush           drops the ready flag
//   capture         load cap_value/cap_tag this cycle
//   snoop_en        allow CDB snooping (station is waiting for operands)
//   cap_value/tag   register-file value and status-table tag
//   cdb_data_in     all data-CDB lanes, lane i at [i*WORD_SIZE +: WORD_SIZE]
//   cdb_valid_in    valid bit per lane
//   cap_ready       combinational: operand will be ready right after capture
//   value, ready    stored operand and its ready flag
// ---------------------------------------------------------------------------
module adder_operand_slot
    import adder_station_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        flush,
    input  logic                        capture,
    input  logic                        snoop_en,
    input  logic [WORD_SIZE-1:0]        cap_value,
    input  logic [RB_INDEX:0]           cap_tag,
    input  logic [RB_SIZE*WORD_SIZE-1:0] cdb_data_in,
    input  logic [RB_SIZE-1:0]          cdb_valid_in,
    output logic                        cap_ready,
    output logic [WORD_SIZE-1:0]        value,
    output logic                        ready
);

    logic [WORD_SIZE-1:0] value_q, value_d;
    logic [RB_INDEX-1:0]  idx_q, idx_d;
    logic                 ready_q, ready_d;
    logic                 fwd_hit;
    logic [RB_INDEX-1:0]  cap_idx;
    logic [WORD_SIZE-1:0] lane [RB_SIZE];

    genvar gi;
    generate
        for (gi = 0; gi < RB_SIZE; gi++) begin : g_lane
            assign lane[gi] = cdb_data_in[gi*WORD_SIZE +: WORD_SIZE];
        end
    endgenerate

    assign cap_idx = cap_tag[RB_INDEX-1:0];

`ifdef ADDER_FORWARD_EN
    assign fwd_hit = !cap_tag[RB_INDEX] && cdb_valid_in[cap_idx];
`else
    assign fwd_hit = 1'b0;
`endif

    assign cap_ready = cap_tag[RB_INDEX] | fwd_hit;

    always_comb begin
        value_d = value_q;
        idx_d   = idx_q;
        ready_d = ready_q;
        if (flush) begin
            ready_d = 1'b0;
        end else if (capture) begin
            idx_d   = cap_idx;
            ready_d = cap_ready;
            value_d = fwd_hit ? lane[cap_idx] : cap_value;
        end else if (snoop_en && !ready_q && cdb_valid_in[idx_q]) begin
            // Lane selected by index only, so RB wrap needs no special case
            value_d = lane[idx_q];
            ready_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value_q <= '0;
            idx_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            value_q <= value_d;
            idx_q   <= idx_d;
            ready_q <= ready_d;
        end
    end

    assign value = value_q;
    assign ready = ready_q;

endmodule

// File: rtl/adder_station.sv
// ---------------------------------------------------------------------------
// adder_station
// Reservation station plus integer adder (ADD/SUB/ADDI/SUBI). Accepts one
// instruction from the instruction CDB when CDB_inst_fu matches FU_ID,
// gathers operands (register file, status table, data-CDB snoop), executes
// for ADD_LATENCY cycles and broadcasts the result for one cycle in the
// data-CDB lane named by the issued RB index.
// Optional feature macro: ADDER_FORWARD_EN (same-cycle operand forwarding
// at capture, handled inside adder_operand_slot).
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   flush                 kill this unit's instruction (synchronous)
//   CDB_inst_fu/inst/RBindex  issued instruction bus
//   numj, numk            rs1/rs2 of the issued instruction (combinational)
//   vj, vk, qj, qk        register-file values and status-table tags
//   CDB_data_data_in/valid_in   data-CDB snoop inputs
//   CDB_data_data_out/valid_out result lane and one-hot valid
//   busy                  station occupied (not IDLE)
// An issue arriving while busy is dropped.
// ---------------------------------------------------------------------------
module adder_station
    import adder_station_pkg::*;
#(
    parameter int FU_ID       = 0,
    parameter int ADD_LATENCY = 2
)(
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         flush,
    input  logic [FU_INDEX-1:0]          CDB_inst_fu,
    input  logic [WORD_SIZE-1:0]         CDB_inst_inst,
    input  logic [RB_INDEX-1:0]          CDB_inst_RBindex,
    output logic [REG_INDEX-1:0]         numj,
    output logic [REG_INDEX-1:0]         numk,
    input  logic [WORD_SIZE-1:0]         vj,
    input  logic [WORD_SIZE-1:0]         vk,
    input  logic [RB_INDEX:0]            qj,
    input  logic [RB_INDEX:0]            qk,
    input  logic [RB_SIZE*WORD_SIZE-1:0] CDB_data_data_in,
    input  logic [RB_SIZE-1:0]           CDB_data_valid_in,
    output logic [RB_SIZE*WORD_SIZE-1:0] CDB_data_data_out,
    output logic [RB_SIZE-1:0]           CDB_data_valid_out,
    output logic                         busy
);

    localparam int CNT_W = (ADD_LATENCY > 1) ? $clog2(ADD_LATENCY) : 1;
    localparam logic [CNT_W-1:0]    CNT_LOAD = CNT_W'(ADD_LATENCY - 1);
    localparam logic [FU_INDEX-1:0] MY_FU    = FU_INDEX'(FU_ID);

    logic [1:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 sub_q, sub_d;
    logic [RB_INDEX-1:0]  rb_idx_q, rb_idx_d;
    logic [WORD_SIZE-1:0] result_q, result_d;

    logic [3:0]           op;
    logic                 op_ok, op_imm, op_sub;
    logic                 capture;
    logic                 snoop_en;
    logic [WORD_SIZE-1:0] k_cap_value;
    logic [RB_INDEX:0]    k_cap_tag;
    logic                 j_cap_ready, k_cap_ready;
    logic [WORD_SIZE-1:0] j_value, k_value;
    logic                 j_ready, k_ready;
    logic                 unused_rd;

    // rd is tracked by the reorder buffer, not by this station
    assign unused_rd = ^CDB_inst_inst[RD_MSB:RD_LSB];

    assign numj = CDB_inst_inst[RS1_MSB:RS1_LSB];
    assign numk = CDB_inst_inst[RS2_MSB:RS2_LSB];

    assign op     = CDB_inst_inst[OP_MSB:OP_LSB];
    assign op_imm = (op == INST_ADDI) || (op == INST_SUBI);
    assign op_sub = (op == INST_SUB)  || (op == INST_SUBI);
    assign op_ok  = op_imm || (op == INST_ADD) || (op == INST_SUB);

    assign capture  = (state_q == ST_IDLE) && (CDB_inst_fu == MY_FU) && op_ok && !flush;
    assign snoop_en = (state_q == ST_WAIT_OPS);

    // Immediate forms replace the k operand with a ready, sign-extended imm
    assign k_cap_value = op_imm ? sext_imm(CDB_inst_inst[IMM_MSB:0]) : vk;
    assign k_cap_tag   = op_imm ? READY_TAG : qk;

    adder_operand_slot u_slot_j (
        .clk          (clk),
        .reset_n      (reset_n),
        .flush        (flush),
        .capture      (capture),
        .snoop_en     (snoop_en),
        .cap_value    (vj),
        .cap_tag      (qj),
        .cdb_data_in  (CDB_data_data_in),
        .cdb_valid_in (CDB_data_valid_in),
        .cap_ready    (j_cap_ready),
        .value        (j_value),
        .ready        (j_ready)
    );

    adder_operand_slot u_slot_k (
        .clk          (clk),
        .reset_n      (reset_n),
        .flush        (flush),
        .capture      (capture),
        .snoop_en     (snoop_en),
        .cap_value    (k_cap_value),
        .cap_tag      (k_cap_tag),
        .cdb_data_in  (CDB_data_data_in),
        .cdb_valid_in (CDB_data_valid_in),
        .cap_ready    (k_cap_ready),
        .value        (k_value),
        .ready        (k_ready)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sub_d    = sub_q;
        rb_idx_d = rb_idx_q;
        result_d = result_q;
        if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (capture) begin
                        sub_d    = op_sub;
                        rb_idx_d = CDB_inst_RBindex;
                        if (j_cap_ready && k_cap_ready) begin
                            state_d = ST_EXEC;
                            cnt_d   = CNT_LOAD;
                        end else begin
                            state_d = ST_WAIT_OPS;
                        end
                    end
                end
                ST_WAIT_OPS: begin
                    if (j_ready && k_ready) begin
                        state_d = ST_EXEC;
                        cnt_d   = CNT_LOAD;
                    end
                end
                ST_EXEC: begin
                    if (cnt_q == '0) begin
                        result_d = sub_q ? (j_value - k_value) : (j_value + k_value);
                        state_d  = ST_BCAST;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_BCAST: state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            sub_q    <= 1'b0;
            rb_idx_q <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sub_q    <= sub_d;
            rb_idx_q <= rb_idx_d;
            result_q <= result_d;
        end
    end

    // Outputs decode straight from registers so reset clears them at once
    assign busy = (state_q != ST_IDLE);

    genvar gi;
    generate
        for (gi = 0; gi < RB_SIZE; gi++) begin : g_out
            assign CDB_data_valid_out[gi] = (state_q == ST_BCAST) && (rb_idx_q == RB_INDEX'(gi));
            assign CDB_data_data_out[gi*WORD_SIZE +: WORD_SIZE] =
                CDB_data_valid_out[gi] ? result_q : '0;
        end
    endgenerate

endmodule
